// File: rtl/multicore_data_mem.sv
// Shared single-port data memory for CORE_COUNT cores. A round-robin arbiter
// with per-core lock picks at most one access per cycle. Read data is
// registered and returns one cycle after the grant.
module multicore_data_mem #(
    parameter int CORE_COUNT          = 4,
    parameter int REG_WIDTH           = 12,
    parameter int DATA_MEM_DEPTH      = 4096,
    parameter int DATA_MEM_ADDR_WIDTH = $clog2(DATA_MEM_DEPTH)
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [CORE_COUNT-1:0]                     req,
    input  logic [CORE_COUNT-1:0]                     wrEn,
    input  logic [CORE_COUNT-1:0]                     lock,
    input  logic [CORE_COUNT*DATA_MEM_ADDR_WIDTH-1:0] addr,
    input  logic [CORE_COUNT*REG_WIDTH-1:0]           dataIn,
    output logic [CORE_COUNT-1:0]                     grant,
    output logic [REG_WIDTH-1:0]                      rdData,
    output logic [CORE_COUNT-1:0]                     rdValid
);

    localparam int PW = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;

    logic [REG_WIDTH-1:0]           mem [DATA_MEM_DEPTH];

    logic [PW-1:0]                  ptr;
    logic                           lock_valid;
    logic [PW-1:0]                  lock_owner;
    logic [REG_WIDTH-1:0]           rd_data_p1;
    logic [CORE_COUNT-1:0]          rd_valid_p1;

    logic                           found;
    logic [PW-1:0]                  winner;
    logic [PW-1:0]                  next_ptr;
    logic                           access;
    logic                           lock_hit;
    logic [DATA_MEM_ADDR_WIDTH-1:0] sel_addr;
    logic [REG_WIDTH-1:0]           sel_data;

    // Arbitration: a live lock wins outright, otherwise search from ptr upward
    always_comb begin
        int idx;
        idx      = 0;
        found    = 1'b0;
        winner   = '0;
        lock_hit = lock_valid && req[lock_owner];
        if (lock_hit) begin
            found  = 1'b1;
            winner = lock_owner;
        end else begin
            for (int i = 0; i < CORE_COUNT; i++) begin
                idx = int'(ptr) + i;
                if (idx >= CORE_COUNT) idx = idx - CORE_COUNT;
                if (!found && req[idx]) begin
                    found  = 1'b1;
                    winner = PW'(idx);
                end
            end
        end
        grant = '0;
        if (found && !rst) grant[winner] = 1'b1;
    end

    assign access   = found && !rst;
    assign next_ptr = (winner == PW'(CORE_COUNT - 1)) ? '0 : winner + PW'(1);
    assign sel_addr = addr[int'(winner)*DATA_MEM_ADDR_WIDTH +: DATA_MEM_ADDR_WIDTH];
    assign sel_data = dataIn[int'(winner)*REG_WIDTH +: REG_WIDTH];

    // Array write for the granted core; contents survive reset
    always_ff @(posedge clk) begin
        if (access && wrEn[winner]) mem[sel_addr] <= sel_data;
    end

    // Arbiter state and registered read port (stage p1)
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr         <= '0;
            lock_valid  <= 1'b0;
            lock_owner  <= '0;
            rd_valid_p1 <= '0;
            rd_data_p1  <= '0;
        end else begin
            rd_valid_p1 <= '0;
            if (lock_valid && !req[lock_owner]) lock_valid <= 1'b0;
            if (access) begin
                if (!wrEn[winner]) begin
                    rd_data_p1          <= mem[sel_addr];
                    rd_valid_p1[winner] <= 1'b1;
                end
                if (lock[winner]) begin
                    lock_valid <= 1'b1;
                    lock_owner <= winner;
                end else begin
                    lock_valid <= 1'b0;
                    ptr        <= next_ptr;
                end
            end
        end
    end

    // A read issued just before reset must not be reported while reset is held
    assign rdValid = rst ? '0 : rd_valid_p1;
    assign rdData  = rd_data_p1;

endmodule
